// File: rtl/alu_pkg.sv
// Shared definitions for the Y-86 execute-stage arithmetic units.
// Holds the opcode encoding, the default datapath sizes and the
// serial adder/subtractor FSM state encoding.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned ADD_WIDTH = 64;
  localparam int unsigned ADD_CHUNK = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } alu_state_e;

endpackage

// File: rtl/add_slice.sv
// Combinational CHUNK-wide ripple slice used by the serial adder.
// Ports:
//   a, b  - slice operands
//   cin   - carry into bit 0
//   sum   - slice sum
//   cout  - carry out of the slice MSB
module add_slice #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/add_sub_serial64.sv
// Multi-cycle adder/subtractor for the Y-86 execute stage.
// One CHUNK-wide slice is computed per cycle through a single add_slice,
// with the inter-slice carry held in a register. Result, overflow and the
// ZF/SF/OF condition-code register are all registered.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake (a, b, op, set_cc)
//   out_valid / out_ready- result handshake (result, overflow)
//   zf, sf, of           - condition-code register outputs
module add_sub_serial64
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH,
  parameter int unsigned CHUNK = ADD_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;  // b, or ~b for subtract
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             set_cc_q, set_cc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d;

  logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;
  int unsigned      slice_lsb;

  assign slice_lsb = int'(cnt_q) * CHUNK;
  assign slice_a   = a_q[slice_lsb +: CHUNK];
  assign slice_b   = b_q[slice_lsb +: CHUNK];

  add_slice #(
    .CHUNK (CHUNK)
  ) u_add_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    set_cc_d    = set_cc_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    zf_d        = zf_q;
    sf_d        = sf_q;
    of_d        = of_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = (op == OP_SUB) ? ~b : b;
          carry_d    = op;  // +1 completes the two's-complement negate
          cnt_d      = '0;
          set_cc_d   = set_cc;
          in_ready_d = 1'b0;
          state_d    = StCalc;
        end
      end
      StCalc: begin
        result_d[slice_lsb +: CHUNK] = slice_sum;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NCHUNK - 1)) begin
          // Carry out of the MSB is dropped; overflow uses the stored b'.
          overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (result_d[WIDTH-1] != a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = StDone;
          if (set_cc_q) begin
            zf_d = (result_d == '0);
            sf_d = result_d[WIDTH-1];
            of_d = overflow_d;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      set_cc_q    <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      set_cc_q    <= set_cc_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;

endmodule
